// File: rtl/fifo_main_push_cond.sv
// ---------------------------------------------------------------------------
// fifo_main_push_cond
//
// Write-side controller for the Main FIFO. Upstream words arrive over a
// valid/ready handshake and are held in a 2-entry skid buffer. The head word
// is written to the Main FIFO (registered Main_wr / Main_data_in) on every
// edge where the Main FIFO is neither almost full nor full. A wrapping counter
// tracks how many writes have been issued since reset.
//
// Optional feature (macro MAIN_PUSH_BYPASS_EN):
//   When the buffer is empty and a word is accepted while the Main FIFO can
//   take it, the word goes straight into Main_data_in on the accepting edge
//   and the buffer stays empty. Without the macro every word spends one edge
//   in the skid buffer.
//
// Parameters:
//   DATA_WIDTH        word width
//   CNT_WIDTH         width of push_count
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   reset             synchronous, active-high reset
//   data_in           upstream word
//   valid_in          upstream word valid
//   ready_out         controller can accept a word this cycle
//   Main_almost_full  Main FIFO almost-full flag
//   Main_full         Main FIFO full flag
//   Main_data_in      word written to the Main FIFO (registered, 0 when idle)
//   Main_wr           Main FIFO write strobe (registered)
//   push_count        number of Main FIFO writes since reset, wraps
// ---------------------------------------------------------------------------
module fifo_main_push_cond #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  Main_almost_full,
    input  logic                  Main_full,
    output logic [DATA_WIDTH-1:0] Main_data_in,
    output logic                  Main_wr,
    output logic [CNT_WIDTH-1:0]  push_count
);

    // Buffer occupancy doubles as the controller state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  main_wr_q, main_wr_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CNT_WIDTH-1:0]  push_count_q, push_count_d;

    logic push;       // handshake completes this cycle
    logic can_write;  // Main FIFO may take a word on this edge
    logic pop;        // head of the skid buffer is written this edge
    logic bypass;     // accepted word goes straight to the Main FIFO
    logic store;      // accepted word is written into the skid buffer

    // ready_out depends only on registered state and reset, never on the
    // Main FIFO flags, so upstream sees no combinational path through us.
    assign ready_out = !reset && (state_q != FULL);
    assign push      = valid_in && ready_out;
    assign can_write = !Main_almost_full && !Main_full;
    assign pop       = (state_q != EMPTY) && can_write;

`ifdef MAIN_PUSH_BYPASS_EN
    assign bypass = (state_q == EMPTY) && push && can_write;
`else
    assign bypass = 1'b0;
`endif

    assign store = push && !bypass;

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q ^ pop;
        tail_d       = tail_q ^ store;
        buf_d        = buf_q;
        main_wr_d    = 1'b0;
        main_data_d  = '0;

        if (store) begin
            buf_d[tail_q] = data_in;
        end

        unique case (state_q)
            EMPTY:   if (store)          state_d = ONE;
            ONE: begin
                if (store && !pop)       state_d = FULL;
                else if (pop && !store)  state_d = EMPTY;
            end
            FULL:    if (pop)            state_d = ONE;
            default:                     state_d = EMPTY;
        endcase

        // Data is forced to zero whenever the strobe is low.
        if (pop) begin
            main_wr_d   = 1'b1;
            main_data_d = buf_q[head_q];
        end else if (bypass) begin
            main_wr_d   = 1'b1;
            main_data_d = data_in;
        end

        // Counts the write being registered on this edge.
        push_count_d = push_count_q + CNT_WIDTH'(main_wr_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            main_wr_q    <= 1'b0;
            main_data_q  <= '0;
            push_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            main_wr_q    <= main_wr_d;
            main_data_q  <= main_data_d;
            push_count_q <= push_count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and occupancy is what reset clears.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign Main_wr      = main_wr_q;
    assign Main_data_in = main_data_q;
    assign push_count   = push_count_q;

endmodule
